// File: rtl/mem_stage_v.sv
// ============================================================================
//  Module   : mem_stage_v
//  Purpose  : Memory-access pipeline stage. Drives a req/ready data-memory
//             port, steers store byte lanes, extracts and extends load data,
//             registers the MEM/WB bundle, and stalls upstream while an
//             access is outstanding. Hung accesses are aborted by a timeout.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stage_v #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  // EX/MEM bundle
  input  logic        mem_isValid,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_instr,
  input  logic [4:0]  mem_rd,
  input  logic        mem_mem_read,
  input  logic        mem_mem_write,
  input  logic        mem_reg_write,
  input  logic [31:0] mem_result,
  input  logic [31:0] mem_sData,
  // data-memory port
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  // pipeline control
  output logic        mem_stall,
  // MEM/WB bundle
  output logic        wb_isValid,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_instr,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  logic [2:0]  funct3;
  logic [1:0]  byte_off;
  logic        access;
  logic        is_store;
  logic        aligned;
  logic        req;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_val;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] done_data;
  logic        done_rw;

  assign funct3   = mem_instr[14:12];
  assign byte_off = mem_result[1:0];
  assign access   = mem_isValid & (mem_mem_read | mem_mem_write);
  // A write flag overrides a simultaneous read flag.
  assign is_store = mem_mem_write;

  // Alignment check; funct3 codes outside the load/store set count as misaligned.
  always_comb begin
    aligned = 1'b0;
    if (is_store) begin
      case (funct3)
        3'b000:  aligned = 1'b1;
        3'b001:  aligned = ~byte_off[0];
        3'b010:  aligned = (byte_off == 2'b00);
        default: aligned = 1'b0;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b100: aligned = 1'b1;
        3'b001, 3'b101: aligned = ~byte_off[0];
        3'b010:         aligned = (byte_off == 2'b00);
        default:        aligned = 1'b0;
      endcase
    end
  end

  // Store byte-lane steering; loads always read the whole word.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = mem_sData;
    if (is_store) begin
      case (funct3)
        3'b000: begin
          lane_be    = 4'b0001 << byte_off;
          lane_wdata = {4{mem_sData[7:0]}};
        end
        3'b001: begin
          lane_be    = 4'b0011 << byte_off;
          lane_wdata = {2{mem_sData[15:0]}};
        end
        default: begin
          lane_be    = 4'b1111;
          lane_wdata = mem_sData;
        end
      endcase
    end
  end

  // Load extraction with sign or zero extension.
  always_comb begin
    case (byte_off)
      2'd0:    sel_byte = dmem_rdata[7:0];
      2'd1:    sel_byte = dmem_rdata[15:8];
      2'd2:    sel_byte = dmem_rdata[23:16];
      default: sel_byte = dmem_rdata[31:24];
    endcase
    sel_half = byte_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3)
      3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_val = {24'd0, sel_byte};
      3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
      3'b101:  load_val = {16'd0, sel_half};
      default: load_val = dmem_rdata;
    endcase
  end

  // Result of a successful access: stores forward the address, loads write back.
  assign done_data = is_store ? mem_result : load_val;
  assign done_rw   = is_store ? 1'b0 : mem_reg_write;

  // The request stays up throughout WAIT; EX/MEM holds, so the port is stable.
  assign req        = (state_q == ST_WAIT) | (access & aligned);
  assign dmem_req   = req;
  assign dmem_we    = req & is_store;
  assign dmem_addr  = {mem_result[31:2], 2'b00};
  assign dmem_be    = lane_be;
  assign dmem_wdata = lane_wdata;
  assign mem_stall  = req & ~dmem_ready;

  // Access FSM, timeout counter and MEM/WB register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wb_isValid   <= 1'b0;
      wb_pc        <= '0;
      wb_instr     <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_data      <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      wb_isValid   <= 1'b0;
      wb_reg_write <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mem_isValid) begin
            if (!access) begin
              wb_isValid   <= 1'b1;
              wb_pc        <= mem_pc;
              wb_instr     <= mem_instr;
              wb_rd        <= mem_rd;
              wb_reg_write <= mem_reg_write;
              wb_data      <= mem_result;
            end else if (!aligned) begin
              wb_isValid   <= 1'b1;
              wb_pc        <= mem_pc;
              wb_instr     <= mem_instr;
              wb_rd        <= mem_rd;
              wb_data      <= mem_result;
              misalign_err <= 1'b1;
            end else if (dmem_ready) begin
              wb_isValid   <= 1'b1;
              wb_pc        <= mem_pc;
              wb_instr     <= mem_instr;
              wb_rd        <= mem_rd;
              wb_reg_write <= done_rw;
              wb_data      <= done_data;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= C_CNT_ONE;
            end
          end
        end
        ST_WAIT: begin
          if (dmem_ready) begin
            wb_isValid   <= 1'b1;
            wb_pc        <= mem_pc;
            wb_instr     <= mem_instr;
            wb_rd        <= mem_rd;
            wb_reg_write <= done_rw;
            wb_data      <= done_data;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
          end else if (cnt_q == C_CNT_LAST) begin
            wb_isValid <= 1'b1;
            wb_pc      <= mem_pc;
            wb_instr   <= mem_instr;
            wb_rd      <= mem_rd;
            wb_data    <= '0;
            bus_err    <= 1'b1;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
          end else begin
            cnt_q <= cnt_q + C_CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_v.sv
// ============================================================================
//  Module   : tb_mem_stage_v
//  Purpose  : Self-checking bench for mem_stage_v: directed scenarios followed
//             by random transactions against a behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_v;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_isValid, mem_mem_read, mem_mem_write, mem_reg_write;
  logic [31:0] mem_pc, mem_instr, mem_result, mem_sData;
  logic [4:0]  mem_rd;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall;
  logic        wb_isValid, wb_reg_write, misalign_err, bus_err;
  logic [31:0] wb_pc, wb_instr, wb_data;
  logic [4:0]  wb_rd;

  int total = 0;
  int bad   = 0;

  // expected MEM/WB state
  logic        e_valid, e_rw, e_mis, e_bus;
  logic [31:0] e_pc, e_instr, e_data;
  logic [4:0]  e_rd;

  mem_stage_v #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .mem_isValid(mem_isValid), .mem_pc(mem_pc), .mem_instr(mem_instr),
    .mem_rd(mem_rd), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_reg_write(mem_reg_write), .mem_result(mem_result), .mem_sData(mem_sData),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .wb_isValid(wb_isValid), .wb_pc(wb_pc), .wb_instr(wb_instr), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * a[1:0]);
    case (f3)
      3'd0:    return 32'($signed(sh[7:0]));
      3'd4:    return sh & 32'h0000_00FF;
      3'd1:    return 32'($signed(sh[15:0]));
      3'd5:    return sh & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  task automatic chk_wb(input string nm);
    chk({nm, ".wb_isValid"},   32'(wb_isValid),   32'(e_valid));
    chk({nm, ".wb_reg_write"}, 32'(wb_reg_write), 32'(e_rw));
    chk({nm, ".wb_data"},      wb_data,           e_data);
    chk({nm, ".wb_pc"},        wb_pc,             e_pc);
    chk({nm, ".wb_instr"},     wb_instr,          e_instr);
    chk({nm, ".wb_rd"},        32'(wb_rd),        32'(e_rd));
    chk({nm, ".misalign_err"}, 32'(misalign_err), 32'(e_mis));
    chk({nm, ".bus_err"},      32'(bus_err),      32'(e_bus));
  endtask

  // One instruction through the stage; lat = cycles of ready low before ready.
  task automatic txn(input bit v, input bit rdf, input bit wrf, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                     input bit rw, input int lat, input logic [31:0] rdata,
                     input string nm);
    bit acc, legal, aligned, req_e, done, abort, rdy;
    int nbytes, c, stalls, exp_stalls;
    logic [31:0] pc, instr, be_e, wd_e;
    pc    = $urandom;
    instr = $urandom;
    instr[14:12] = f3;
    @(negedge clk);
    mem_isValid = v; mem_mem_read = rdf; mem_mem_write = wrf; mem_reg_write = rw;
    mem_pc = pc; mem_instr = instr; mem_rd = rd; mem_result = addr; mem_sData = sd;

    acc     = v && (rdf || wrf);
    legal   = wrf ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    nbytes  = 1 << f3[1:0];
    aligned = legal && ((addr % nbytes) == 0);
    req_e   = acc && aligned;
    be_e    = wrf ? (((32'd1 << nbytes) - 1) << addr[1:0]) : 32'hF;
    wd_e    = !wrf ? sd : (f3 == 0) ? (sd & 32'hFF) * 32'h0101_0101 :
              (f3 == 1) ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
    exp_stalls = (lat < TO) ? lat : TO;

    c = 0; done = 0; abort = 0; stalls = 0;
    while (!done) begin
      rdy        = req_e ? (c == lat) : 1'($urandom % 2);
      dmem_ready = rdy;
      dmem_rdata = (req_e && rdy) ? rdata : $urandom;
      #1;
      chk({nm, ".dmem_req"},  32'(dmem_req),  32'(req_e));
      chk({nm, ".mem_stall"}, 32'(mem_stall), 32'(req_e && !rdy));
      if (req_e) begin
        chk({nm, ".dmem_we"},    32'(dmem_we),   32'(wrf));
        chk({nm, ".dmem_addr"},  dmem_addr,      addr & 32'hFFFF_FFFC);
        chk({nm, ".dmem_be"},    32'(dmem_be),   be_e);
        chk({nm, ".dmem_wdata"}, dmem_wdata,     wd_e);
      end
      if (mem_stall) stalls++;
      @(posedge clk); #1;
      if (!req_e || rdy) done = 1;
      else if (c == TO - 1) begin done = 1; abort = 1; end

      e_mis = 0; e_bus = 0;
      if (!done || !v) begin
        e_valid = 0; e_rw = 0;
      end else begin
        e_valid = 1; e_pc = pc; e_instr = instr; e_rd = rd;
        if (!acc) begin
          e_rw = rw; e_data = addr;
        end else if (!aligned) begin
          e_rw = 0; e_data = addr; e_mis = 1;
        end else if (abort) begin
          e_rw = 0; e_data = 0; e_bus = 1;
        end else if (wrf) begin
          e_rw = 0; e_data = addr;
        end else begin
          e_rw = rw; e_data = exp_load(f3, addr, rdata);
        end
      end
      chk_wb(nm);
      c++;
      if (!done) @(negedge clk);
    end
    if (req_e) chk({nm, ".stall_cycles"}, 32'(stalls), 32'(exp_stalls));
  endtask

  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    reset = 1'b1;
    mem_isValid = 0; mem_mem_read = 0; mem_mem_write = 0; mem_reg_write = 0;
    mem_pc = 0; mem_instr = 0; mem_rd = 0; mem_result = 0; mem_sData = 0;
    dmem_ready = 0; dmem_rdata = 0;
    e_valid = 0; e_rw = 0; e_mis = 0; e_bus = 0;
    e_pc = 0; e_instr = 0; e_data = 0; e_rd = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.dmem_req",  32'(dmem_req),  32'd0);
    chk("reset.mem_stall", 32'(mem_stall), 32'd0);
    chk_wb("reset");
    @(negedge clk);
    reset = 1'b0;

    // directed scenarios
    txn(1, 1, 0, 3'd2, 32'h100, 0, 5'd5, 1, 0, 32'hDEAD_BEEF, "lw_zero_wait");
    txn(1, 1, 0, 3'd0, 32'h103, 0, 5'd6, 1, 3, 32'h80FF_0000, "lb_wait3");
    txn(1, 1, 0, 3'd4, 32'h103, 0, 5'd6, 1, 3, 32'h80FF_0000, "lbu_wait3");
    txn(1, 0, 1, 3'd1, 32'h102, 32'h1234_ABCD, 5'd7, 1, 0, 0, "sh_upper");
    txn(1, 1, 0, 3'd2, 32'h101, 0, 5'd8, 1, 0, 0, "lw_misaligned");
    txn(1, 1, 0, 3'd2, 32'h200, 0, 5'd9, 1, 1000, 0, "lw_timeout");
    txn(1, 0, 0, 3'd0, 32'd7, 0, 5'd10, 1, 0, 0, "add_after_abort");
    txn(1, 1, 0, 3'd2, 32'h300, 0, 5'd11, 1, TO - 1, 32'h0BAD_F00D, "lw_ready_at_expiry");
    txn(0, 1, 0, 3'd2, 32'h400, 0, 5'd12, 1, 0, 0, "bubble");

    // reset asserted in the second WAIT cycle
    @(negedge clk);
    mem_isValid = 1; mem_mem_read = 1; mem_mem_write = 0; mem_reg_write = 1;
    mem_instr = 32'h0000_2003; mem_result = 32'h500; dmem_ready = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1; mem_isValid = 0;
    @(posedge clk); #1;
    e_valid = 0; e_rw = 0; e_mis = 0; e_bus = 0;
    e_pc = 0; e_instr = 0; e_data = 0; e_rd = 0;
    chk("rst_wait.dmem_req",  32'(dmem_req),  32'd0);
    chk("rst_wait.mem_stall", 32'(mem_stall), 32'd0);
    chk_wb("rst_wait");
    @(negedge clk);
    reset = 1'b0;

    // random traffic
    for (int i = 0; i < 80; i++) begin
      int kind, lat;
      bit wrf, rdf;
      logic [2:0]  f3;
      logic [31:0] addr;
      kind = $urandom_range(0, 9);
      wrf  = 1'($urandom % 2);
      rdf  = wrf ? 1'($urandom % 2) : 1'b1;
      if ($urandom % 5 == 0) f3 = 3'($urandom);
      else f3 = wrf ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      addr = $urandom;
      if ($urandom % 2 == 0) addr[1:0] = 2'b00;
      lat  = ($urandom % 8 == 0) ? 100 : $urandom_range(0, 4);
      if (kind == 0)
        txn(0, rdf, wrf, f3, addr, $urandom, 5'($urandom), 1'($urandom), lat, $urandom, "rnd_bubble");
      else if (kind == 1)
        txn(1, 0, 0, f3, addr, $urandom, 5'($urandom), 1'($urandom), lat, $urandom, "rnd_alu");
      else
        txn(1, rdf, wrf, f3, addr, $urandom, 5'($urandom), 1'($urandom), lat, $urandom, "rnd_mem");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/mem_stage_v.md
Name: mem_stage_v

Overview:
- Memory-access stage directly downstream of the EX/MEM pipeline register; consumes its mem_* bundle.
- Drives a ready/req data-memory port and performs store byte-lane steering and load extraction/extension.
- Registers results into the MEM/WB bundle.
- Stalls the pipeline during multi-cycle memory accesses; aborts hung accesses via a timeout counter.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in WAIT before abort (≥2).
- CNT_W, 5: timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- mem_isValid  in  1  EX/MEM bundle valid.
- mem_pc, mem_instr  in  32 each  PC and instruction; funct3 = mem_instr[14:12].
- mem_rd  in  5  destination register.
- mem_mem_read, mem_mem_write, mem_reg_write  in  1 each  control bits.
- mem_result  in  32  ALU result; memory byte address for loads/stores.
- mem_sData  in  32  store data.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  {mem_result[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-steered store data.
- dmem_ready  in  1  access complete this cycle.
- dmem_rdata  in  32  read word, valid when dmem_ready=1.
- mem_stall  out  1  freeze upstream; EX/MEM holds its contents while high.
- wb_isValid  out  1  MEM/WB valid.
- wb_pc, wb_instr  out  32 each  passed through.
- wb_rd  out  5  passed through.
- wb_reg_write  out  1  write-back enable.
- wb_data  out  32  load data or mem_result.
- misalign_err, bus_err  out  1 each  one-cycle error pulses.

Behaviour:
- Clock and reset: clk only; reset is synchronous, active-high.
- Reset: FSM=IDLE, counter=0. All wb_* outputs, misalign_err and bus_err = 0. dmem_req=0, mem_stall=0.
- Access = mem_isValid & (mem_mem_read | mem_mem_write). If both read and write are set, write wins.
- Alignment:
  - Halfword: requires addr[0]=0.
  - Word: requires addr[1:0]=0.
  - funct3 values other than the load/store set, when an access is flagged, are treated as misaligned.
- Store lanes:
  - SB(000): be=0001<<addr[1:0]; wdata = byte replicated ×4.
  - SH(001): be=0011<<addr[1:0]; wdata = half replicated ×2.
  - SW(010): be=1111.
- Loads (be=1111, word read):
  - LB(000)/LBU(100): select byte addr[1:0], sign/zero-extend.
  - LH(001)/LHU(101): select half addr[1], sign/zero-extend.
  - LW(010): whole word.
- FSM states IDLE, WAIT.
- IDLE, aligned access:
  - dmem_req=1 combinationally this cycle; dmem_addr/be/we/wdata are driven from the mem_* inputs.
  - dmem_ready=1 same cycle: zero-wait. mem_stall=0; complete at this edge.
  - Else: mem_stall=1, go WAIT, counter=1.
- WAIT:
  - Hold dmem_req=1 and stable dmem_* outputs; mem_stall=1.
  - dmem_ready=1: mem_stall=0 that cycle; complete at edge; go IDLE.
  - Else, if counter==TIMEOUT_CYCLES-1: abort at edge with bus_err; go IDLE.
  - Else counter+1.
- Completion (registered at edge):
  - wb_isValid=1; wb_pc, wb_instr, wb_rd copied.
  - Load: wb_data = extracted value, wb_reg_write = mem_reg_write.
  - Store: wb_data = mem_result, wb_reg_write=0.
- Non-access valid instruction: one-cycle pass-through. wb_data=mem_result; wb_reg_write=mem_reg_write; no request.
- Misaligned access:
  - No dmem_req; no stall.
  - Completes next edge with wb_isValid=1, wb_reg_write=0, wb_data=mem_result, misalign_err=1 for one cycle.
- Abort (timeout): wb_isValid=1, wb_reg_write=0, wb_data=0, bus_err=1 for one cycle; the pipeline resumes.
- Bubble: in any cycle with no completion (mem_isValid=0, or a stalled WAIT cycle), at the edge wb_isValid=0 and wb_reg_write=0. Other wb_* fields hold their values.
- Error pulses last exactly one cycle.
- Reset mid-WAIT: the request drops in the cycle after the reset edge. No completion, no error pulse.
- Late dmem_ready: dmem_ready in IDLE without a request is ignored. A ready arriving in the same cycle as timeout expiry counts as success.

Test Plan:
- LW, addr 0x100, dmem_ready same cycle, rdata 0xDEADBEEF, rd=5 → no stall; next cycle wb_data=0xDEADBEEF, wb_reg_write=1, wb_rd=5.
- LB, addr 0x103, rdata 0x80FF_0000, ready after 3 wait cycles → mem_stall high exactly 3 cycles; wb_data=0xFFFFFF80. Repeat as LBU → 0x00000080.
- SH, addr 0x102, sData 0x1234ABCD → be=1100, wdata=0xABCDABCD, we=1; wb_reg_write=0.
- LW, addr 0x101 → no dmem_req, misalign_err single pulse, wb_isValid=1, wb_reg_write=0.
- Load with dmem_ready never asserted → stall for exactly TIMEOUT_CYCLES cycles, then bus_err pulse, wb_data=0. Following ADD (result 7) → wb_data=7.
- Reset asserted in 2nd WAIT cycle → next cycle dmem_req=0, all wb_* and error outputs 0, FSM=IDLE.
